// File: rtl/writeback_stage.sv
// Final RV32I pipeline stage: retires one MEM-stage instruction per transfer into the
// register-file write port. It selects the writeback source (ALU result, load data or PC+4).
// For loads it waits on a variable-latency data-memory response, then aligns and extends it.
// Ports: clk/reset (sync, active-high); mem_valid_i/mem_ready_o handshake with MEM stage;
// captured fields result_src_i, reg_write_i, dest_reg_i, funct3_i, addr_lo_i, alu_result_i,
// pc_plus4_i; dmem_rvalid_i/dmem_rdata_i load response; wr_data_o, reg_file_writeen_o,
// dest_reg_o register-file write port; busy_o; retire_count_o retired-instruction counter.
module writeback_stage #(
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic [1:0]              result_src_i,
    input  logic                    reg_write_i,
    input  logic [4:0]              dest_reg_i,
    input  logic [2:0]              funct3_i,
    input  logic [1:0]              addr_lo_i,
    input  logic [31:0]             alu_result_i,
    input  logic [31:0]             pc_plus4_i,
    input  logic                    dmem_rvalid_i,
    input  logic [31:0]             dmem_rdata_i,
    output logic [31:0]             wr_data_o,
    output logic                    reg_file_writeen_o,
    output logic [4:0]              dest_reg_o,
    output logic                    busy_o,
    output logic [RETIRE_CNT_W-1:0] retire_count_o
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_LOAD = 2'd1;
    localparam logic [1:0] WRITE     = 2'd2;

    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [1:0]  src_q;
    logic        rw_q;
    logic [4:0]  dest_q;
    logic [2:0]  f3_q;
    logic [1:0]  alo_q;
    logic [31:0] alu_q;
    logic [31:0] pc4_q;
    logic [31:0] load_q;
    logic [31:0] last_data;
    logic [4:0]  last_dest;
    logic [31:0] ext;
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] wb_data;
    logic        xfer;
    logic        in_write;

    assign in_write    = (state == WRITE);
    assign mem_ready_o = !reset && (state == IDLE || in_write);
    assign xfer        = mem_valid_i && mem_ready_o;
    assign busy_o      = (state != IDLE);

    // Byte lanes select on the low address bits; halfword ignores addr_lo[0].
    assign sh_b = dmem_rdata_i >> {alo_q, 3'b000};
    assign sh_h = dmem_rdata_i >> {alo_q[1], 4'b0000};

    always_comb begin
        ext = dmem_rdata_i;
        case (f3_q)
            3'b000:  ext = {{24{sh_b[7]}}, sh_b[7:0]};
            3'b001:  ext = {{16{sh_h[15]}}, sh_h[15:0]};
            3'b100:  ext = {24'd0, sh_b[7:0]};
            3'b101:  ext = {16'd0, sh_h[15:0]};
            default: ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        wb_data = alu_q;
        if (src_q == SRC_LOAD) begin
            wb_data = load_q;
        end else if (src_q == SRC_PC4) begin
            wb_data = pc4_q;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_next = (result_src_i == SRC_LOAD) ? WAIT_LOAD : WRITE;
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid_i) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (xfer) begin
                    state_next = (result_src_i == SRC_LOAD) ? WAIT_LOAD : WRITE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write port is live only in WRITE; otherwise it shows the last written values.
    assign wr_data_o          = in_write ? wb_data : last_data;
    assign dest_reg_o         = in_write ? dest_q : last_dest;
    assign reg_file_writeen_o = in_write && rw_q && (dest_q != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            last_data      <= 32'd0;
            last_dest      <= 5'd0;
            retire_count_o <= '0;
        end else begin
            state <= state_next;
            if (in_write) begin
                last_data      <= wb_data;
                last_dest      <= dest_q;
                retire_count_o <= retire_count_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            src_q  <= result_src_i;
            rw_q   <= reg_write_i;
            dest_q <= dest_reg_i;
            f3_q   <= funct3_i;
            alo_q  <= addr_lo_i;
            alu_q  <= alu_result_i;
            pc4_q  <= pc_plus4_i;
        end
        if (state == WAIT_LOAD && dmem_rvalid_i) begin
            load_q <= ext;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed steps, expected writes in a queue
// popped whenever the DUT strobes the register-file write enable.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [1:0]  result_src_i;
    logic        reg_write_i;
    logic [4:0]  dest_reg_i;
    logic [2:0]  funct3_i;
    logic [1:0]  addr_lo_i;
    logic [31:0] alu_result_i;
    logic [31:0] pc_plus4_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] wr_data_o;
    logic        reg_file_writeen_o;
    logic [4:0]  dest_reg_o;
    logic        busy_o;
    logic [31:0] retire_count_o;

    int checks   = 0;
    int failures = 0;
    int nwrites  = 0;
    logic [36:0] expq[$];

    always #5 clk = ~clk;

    writeback_stage #(.RETIRE_CNT_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .mem_valid_i(mem_valid_i),
        .mem_ready_o(mem_ready_o),
        .result_src_i(result_src_i),
        .reg_write_i(reg_write_i),
        .dest_reg_i(dest_reg_i),
        .funct3_i(funct3_i),
        .addr_lo_i(addr_lo_i),
        .alu_result_i(alu_result_i),
        .pc_plus4_i(pc_plus4_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i),
        .wr_data_o(wr_data_o),
        .reg_file_writeen_o(reg_file_writeen_o),
        .dest_reg_o(dest_reg_o),
        .busy_o(busy_o),
        .retire_count_o(retire_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reg_file_writeen_o === 1'b1) begin
            nwrites++;
            if (expq.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [36:0] e;
                e = expq.pop_front();
                chk("wr_data", wr_data_o, e[31:0]);
                chk("dest_reg", {27'd0, dest_reg_o}, {27'd0, e[36:32]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one transfer; the edge at the end of this task accepts it.
    task automatic send(input logic [1:0] src, input logic rw,
                        input logic [4:0] dest, input logic [2:0] f3,
                        input logic [1:0] alo, input logic [31:0] alu,
                        input logic [31:0] pc4, input bit exp_we,
                        input logic [31:0] exp_data);
        mem_valid_i  = 1'b1;
        result_src_i = src;
        reg_write_i  = rw;
        dest_reg_i   = dest;
        funct3_i     = f3;
        addr_lo_i    = alo;
        alu_result_i = alu;
        pc_plus4_i   = pc4;
        if (exp_we) expq.push_back({dest, exp_data});
        step();
    endtask

    // Load response arrives 'lat' cycles after the accepting edge.
    task automatic respond(input int lat, input logic [31:0] rdata);
        mem_valid_i = 1'b0;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("ready_wait", {31'd0, mem_ready_o}, 32'd0);
            chk("busy_wait", {31'd0, busy_o}, 32'd1);
            step();
        end
        dmem_rdata_i  = rdata;
        dmem_rvalid_i = 1'b1;
        step();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'hDEAD_BEEF;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        mem_valid_i   = 1'b0;
        result_src_i  = 2'b00;
        reg_write_i   = 1'b0;
        dest_reg_i    = 5'd0;
        funct3_i      = 3'd0;
        addr_lo_i     = 2'd0;
        alu_result_i  = 32'd0;
        pc_plus4_i    = 32'd0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        step();
        step();
        @(negedge clk);
        chk("rst_wr_data", wr_data_o, 32'd0);
        chk("rst_writeen", {31'd0, reg_file_writeen_o}, 32'd0);
        chk("rst_dest", {27'd0, dest_reg_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_count", retire_count_o, 32'd0);
        chk("rst_ready", {31'd0, mem_ready_o}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("ready_idle", {31'd0, mem_ready_o}, 32'd1);

        // ALU write
        send(2'b00, 1'b1, 5'd5, 3'd0, 2'd0, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678);
        mem_valid_i = 1'b0;
        chk("alu_writeen", {31'd0, reg_file_writeen_o}, 32'd1);
        step();
        chk("alu_count", retire_count_o, 32'd1);
        chk("alu_hold_data", wr_data_o, 32'h1234_5678);
        chk("alu_idle_busy", {31'd0, busy_o}, 32'd0);

        // LB / LBU at byte 3
        send(2'b01, 1'b1, 5'd7, 3'b000, 2'd3, 32'd3, 32'd0, 1'b1, 32'hFFFF_FF80);
        respond(3, 32'h80FF_7F01);
        send(2'b01, 1'b1, 5'd8, 3'b100, 2'd3, 32'd3, 32'd0, 1'b1, 32'h0000_0080);
        respond(3, 32'h80FF_7F01);
        chk("lb_count", retire_count_o, 32'd3);

        // LHU / LH / LW at offset 2
        send(2'b01, 1'b1, 5'd9, 3'b101, 2'd2, 32'd2, 32'd0, 1'b1, 32'h0000_BEEF);
        respond(1, 32'hBEEF_0000);
        send(2'b01, 1'b1, 5'd10, 3'b001, 2'd2, 32'd2, 32'd0, 1'b1, 32'hFFFF_BEEF);
        respond(2, 32'hBEEF_0000);
        send(2'b01, 1'b1, 5'd11, 3'b010, 2'd2, 32'd2, 32'd0, 1'b1, 32'hBEEF_0000);
        respond(1, 32'hBEEF_0000);
        chk("lh_count", retire_count_o, 32'd6);

        // PC+4 source and reserved source (acts as ALU)
        send(2'b10, 1'b1, 5'd1, 3'd0, 2'd0, 32'h5555_0000, 32'h0000_0104, 1'b1, 32'h0000_0104);
        send(2'b11, 1'b1, 5'd2, 3'd0, 2'd0, 32'hA5A5_A5A5, 32'h0000_0200, 1'b1, 32'hA5A5_A5A5);
        mem_valid_i = 1'b0;
        step();
        chk("src_count", retire_count_o, 32'd8);

        // Back-to-back ALU instructions
        begin
            int w0;
            w0 = nwrites;
            for (int i = 0; i < 4; i++) begin
                send(2'b00, 1'b1, 5'(12 + i), 3'd0, 2'd0, 32'(32'h1000 * (i + 1)),
                     32'd0, 1'b1, 32'(32'h1000 * (i + 1)));
                chk("b2b_ready", {31'd0, mem_ready_o}, 32'd1);
            end
            mem_valid_i = 1'b0;
            step();
            chk("b2b_writes", 32'(nwrites - w0), 32'd4);
            chk("b2b_count", retire_count_o, 32'd12);
        end

        // x0 destination: retires without a strobe; stray rvalid while idle
        begin
            int w0;
            w0 = nwrites;
            send(2'b10, 1'b1, 5'd0, 3'd0, 2'd0, 32'd0, 32'h0000_0300, 1'b0, 32'd0);
            mem_valid_i = 1'b0;
            step();
            chk("x0_count", retire_count_o, 32'd13);
            dmem_rvalid_i = 1'b1;
            step();
            dmem_rvalid_i = 1'b0;
            step();
            chk("stray_busy", {31'd0, busy_o}, 32'd0);
            chk("stray_count", retire_count_o, 32'd13);
            chk("x0_no_write", 32'(nwrites - w0), 32'd0);
        end

        // Reset while waiting on a load; late rvalid must be ignored
        send(2'b01, 1'b1, 5'd20, 3'b010, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        mem_valid_i = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rst_ready_low", {31'd0, mem_ready_o}, 32'd0);
        step();
        reset = 1'b0;
        dmem_rdata_i  = 32'h0BAD_0BAD;
        dmem_rvalid_i = 1'b1;
        step();
        dmem_rvalid_i = 1'b0;
        step();
        chk("rst_mid_count", retire_count_o, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mid_ready", {31'd0, mem_ready_o}, 32'd1);
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
